cfu_l1_to_l2_shim: RTL and testbench

Adapter between an L2 (ready/valid) CFU-LI requester and a fixed-latency L1 CFU. It accepts L2 requests, issues them to the L1 CFU, and captures each L1 response into a response FIFO. The L2 requester can therefore backpressure responses without any being lost. A credit counter throttles `req_ready` so that in-flight requests plus buffered responses never exceed FIFO capacity.

---
 rtl/cfu_l1_to_l2_shim.sv | 185 ++++++++++++++++++
 tb/tb_cfu_l1_to_l2_shim.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cfu_l1_to_l2_shim.sv
// cfu_l1_to_l2_shim: bridges a ready/valid (L2) CFU-LI requester onto a
// fixed-latency (L1) CFU. L1 responses land in a small FIFO so the requester
// can stall responses; a credit counter keeps in-flight + buffered <= DEPTH.

package cfu_li_pkg;
  typedef logic [2:0] cfu_status_t;
  localparam cfu_status_t CFU_OK    = 3'd0;
  localparam cfu_status_t CFU_ERROR = 3'd1;
endpackage

module cfu_l1_to_l2_shim
  import cfu_li_pkg::*;
#(
  parameter int unsigned CFU_LI_VERSION = 'h01_00_00,
  parameter int unsigned CFU_N_CFUS     = 1,
  parameter int unsigned CFU_N_STATES   = 1,
  parameter int unsigned CFU_LATENCY    = 2,
  parameter int unsigned CFU_FUNC_ID_W  = 10,
  parameter int unsigned CFU_INSN_W     = 0,
  parameter int unsigned CFU_DATA_W     = 32,
  parameter int unsigned DEPTH          = CFU_LATENCY + 1,
  localparam int unsigned CFU_CFU_ID_W   = $clog2(CFU_N_CFUS),
  localparam int unsigned CFU_STATE_ID_W = $clog2(CFU_N_STATES),
  // Zero-width fields are carried as a single (ignored) bit on the ports.
  localparam int unsigned CID_PW  = (CFU_CFU_ID_W   > 0) ? CFU_CFU_ID_W   : 1,
  localparam int unsigned SID_PW  = (CFU_STATE_ID_W > 0) ? CFU_STATE_ID_W : 1,
  localparam int unsigned INSN_PW = (CFU_INSN_W     > 0) ? CFU_INSN_W     : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  // L2 request
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CID_PW-1:0]        req_cfu,
  input  logic [SID_PW-1:0]        req_state,
  input  logic [CFU_FUNC_ID_W-1:0] req_func,
  input  logic [INSN_PW-1:0]       req_insn,
  input  logic [CFU_DATA_W-1:0]    req_data0,
  input  logic [CFU_DATA_W-1:0]    req_data1,
  // L2 response
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output cfu_status_t              resp_status,
  output logic [CFU_DATA_W-1:0]    resp_data,
  // L1 request
  output logic                     cfu_req_valid,
  output logic [CID_PW-1:0]        cfu_req_cfu,
  output logic [SID_PW-1:0]        cfu_req_state,
  output logic [CFU_FUNC_ID_W-1:0] cfu_req_func,
  output logic [CFU_DATA_W-1:0]    cfu_req_data0,
  output logic [CFU_DATA_W-1:0]    cfu_req_data1,
  // L1 response
  input  logic                     cfu_resp_valid,
  input  cfu_status_t              cfu_resp_status,
  input  logic [CFU_DATA_W-1:0]    cfu_resp_data,
  output logic                     proto_err
);

  // Elaboration-time parameter sanity
  if (CFU_LI_VERSION != 32'h01_00_00) begin : g_bad_version
    $error("cfu_l1_to_l2_shim: unsupported CFU_LI_VERSION");
  end
  if (CFU_DATA_W != 32 && CFU_DATA_W != 64) begin : g_bad_data_w
    $error("cfu_l1_to_l2_shim: CFU_DATA_W must be 32 or 64");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("cfu_l1_to_l2_shim: DEPTH must be >= 1");
  end

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    cfu_status_t           status;
    logic [CFU_DATA_W-1:0] data;
  } rsp_t;

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  rsp_t          mem_q [DEPTH];
  rsp_t          mem_d [DEPTH];
  rsp_t          head_q, head_d;
  logic          resp_valid_q, resp_valid_d;
  logic          proto_err_q, proto_err_d;
  logic          accept, pop, push, full, expect_rsp;
  logic          unused_insn;

  assign unused_insn = ^req_insn;

  // Handshakes. A pop in the same cycle frees a slot, so an accept is still
  // safe at zero credits; this is what sustains one request per cycle.
  assign pop       = clk_en && resp_valid_q && resp_ready;
  assign req_ready = !rst && clk_en && (credits_q != '0 || pop);
  assign accept    = req_valid && req_ready;
  assign full      = (cnt_q == FULL);
  assign push      = clk_en && cfu_resp_valid && (!full || pop);

  assign cfu_req_valid = accept;
  assign cfu_req_cfu   = req_cfu;
  assign cfu_req_state = req_state;
  assign cfu_req_func  = req_func;
  assign cfu_req_data0 = req_data0;
  assign cfu_req_data1 = req_data1;

  assign resp_valid  = resp_valid_q;
  assign resp_status = head_q.status;
  assign resp_data   = head_q.data;
  assign proto_err   = proto_err_q;

  // Issue tracker: bit LATENCY-1 flags the cycle a response is due
  if (CFU_LATENCY == 0) begin : g_lat0
    assign expect_rsp = accept;
  end else begin : g_trk
    logic [CFU_LATENCY-1:0] trk_q, trk_d;
    // Shift in accepts while enabled
    always_comb begin
      trk_d = trk_q;
      if (clk_en) trk_d = (trk_q << 1) | CFU_LATENCY'(accept);
    end
    // Tracker register
    always_ff @(posedge clk) begin
      if (rst) trk_q <= '0;
      else     trk_q <= trk_d;
    end
    assign expect_rsp = trk_q[CFU_LATENCY-1];
  end

  // Next-state for credits, FIFO, registered head and error flag
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)                          credits_d = credits_q - 1'b1;
    else if (pop && !accept && credits_q != FULL) credits_d = credits_q + 1'b1;

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = {cfu_resp_status, cfu_resp_data};
      wr_d        = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (pop) rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Output register tracks the head the FIFO will present next cycle
    resp_valid_d = (cnt_d != '0);
    head_d       = mem_d[rd_d];

    proto_err_d = proto_err_q;
    if (clk_en && ((cfu_resp_valid != expect_rsp) || (cfu_resp_valid && full && !pop)))
      proto_err_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= FULL;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      resp_valid_q <= 1'b0;
      head_q       <= '{status: CFU_OK, data: '0};
      proto_err_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      credits_q    <= credits_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      head_q       <= head_d;
      proto_err_q  <= proto_err_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_cfu_l1_to_l2_shim.sv
// Bench for cfu_l1_to_l2_shim: a latency-2 CFU stand-in plus a queue-based
// reference of outstanding and buffered responses, checked every cycle.
module tb_cfu_l1_to_l2_shim;
  localparam int LAT = 2;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst, clk_en, inj;
  logic        req_valid, req_ready, resp_valid, resp_ready, proto_err;
  logic        cfu_req_valid, cfu_resp_valid;
  logic [0:0]  req_cfu, req_state, req_insn, cfu_req_cfu, cfu_req_state;
  logic [9:0]  req_func, cfu_req_func;
  logic [31:0] req_data0, req_data1, resp_data, cfu_req_data0, cfu_req_data1, cfu_resp_data;
  logic [2:0]  resp_status, cfu_resp_status;

  always #5 clk = ~clk;

  cfu_l1_to_l2_shim #(.CFU_LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfu(req_cfu), .req_state(req_state),
    .req_func(req_func), .req_insn(req_insn), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data),
    .cfu_req_valid(cfu_req_valid), .cfu_req_cfu(cfu_req_cfu), .cfu_req_state(cfu_req_state),
    .cfu_req_func(cfu_req_func), .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_status(cfu_resp_status), .cfu_resp_data(cfu_resp_data),
    .proto_err(proto_err)
  );

  // Stand-in L1 CFU: result = 3*data0 + data1, status = func[2:0], 2 cycles
  logic        v0, v1;
  logic [31:0] d0, d1;
  logic [2:0]  s0, s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0; v1 <= 1'b0; d0 <= '0; d1 <= '0; s0 <= '0; s1 <= '0;
    end else if (clk_en) begin
      v0 <= cfu_req_valid;
      v1 <= v0;
      d0 <= cfu_req_data0 * 32'd3 + cfu_req_data1;
      d1 <= d0;
      s0 <= cfu_req_func[2:0];
      s1 <= s0;
    end
  end
  assign cfu_resp_valid  = v1 | inj;
  assign cfu_resp_data   = d1;
  assign cfu_resp_status = s1;

  // Reference: pending = accepted, not yet in FIFO; bufq = buffered in order
  typedef struct { int unsigned due; logic [34:0] rsp; } pend_t;
  pend_t       pendq[$];
  logic [34:0] bufq[$];
  int unsigned ecyc = 0;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rnd();
    req_data0 = $urandom;
    req_data1 = $urandom;
    req_func  = 10'($urandom);
  endtask

  // One clock: drive, (optionally) check against the reference, advance it
  task automatic step(input bit rv, input bit rr, input bit ce, input bit rs,
                      input bit inj_i, input bit do_chk);
    logic        exp_pop, exp_rdy, acc;
    logic [31:0] res;
    pend_t       p;
    req_valid = rv; resp_ready = rr; clk_en = ce; rst = rs; inj = inj_i;
    #1;
    exp_pop = !rs && ce && bufq.size() != 0 && rr;
    exp_rdy = !rs && ce && ((pendq.size() + bufq.size() < DEPTH) || exp_pop);
    acc     = rv && exp_rdy;
    if (do_chk) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("cfu_req_valid", cfu_req_valid, acc);
      chk("cfu_req_data0", cfu_req_data0, req_data0);
      chk("resp_valid", resp_valid, bufq.size() != 0);
      if (bufq.size() != 0) begin
        chk("resp_data", resp_data, bufq[0][31:0]);
        chk("resp_status", resp_status, bufq[0][34:32]);
      end
      chk("proto_err", proto_err, 1'b0);
    end
    if (rs) begin
      pendq.delete();
      bufq.delete();
    end else if (ce) begin
      if (exp_pop) void'(bufq.pop_front());
      if (pendq.size() != 0 && pendq[0].due == ecyc) bufq.push_back(pendq.pop_front().rsp);
      if (acc) begin
        res   = req_data0 * 32'd3 + req_data1;
        p.due = ecyc + LAT;
        p.rsp = {req_func[2:0], res};
        pendq.push_back(p);
      end
      ecyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; inj = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_cfu = '0; req_state = '0; req_insn = '0; req_func = '0; req_data0 = '0; req_data1 = '0;
    @(negedge clk);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    // Reset state (rst still high here)
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_status", resp_status, 3'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_proto_err", proto_err, 1'b0);

    // Single op: data0 = 7 -> 0x15, visible 3 cycles after the accept
    step(0, 0, 1, 0, 0, 1);
    req_data0 = 32'd7; req_data1 = 32'd0; req_func = 10'd0;
    step(1, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    #1;
    chk("single_valid", resp_valid, 1'b1);
    chk("single_data", resp_data, 32'h15);
    chk("single_status", resp_status, 3'd0);
    step(0, 1, 1, 0, 0, 1);
    repeat (3) step(0, 1, 1, 0, 0, 1);

    // Streaming, then a 4-cycle clock-enable hole mid-stream
    for (int i = 0; i < 12; i++) begin rnd(); step(1, 1, 1, 0, 0, 1); end
    for (int i = 0; i < 4; i++)  begin rnd(); step(1, 1, 0, 0, 0, 1); end
    for (int i = 0; i < 8; i++)  begin rnd(); step(1, 1, 1, 0, 0, 1); end
    repeat (5) step(0, 1, 1, 0, 0, 1);

    // Backpressure: 5+ offers with resp_ready low, then drain
    for (int i = 0; i < 7; i++) begin rnd(); step(1, 0, 1, 0, 0, 1); end
    repeat (6) step(0, 1, 1, 0, 0, 1);

    // Full FIFO with pop + accept each cycle across pointer wraps
    for (int i = 0; i < 6; i++) begin rnd(); step(1, 0, 1, 0, 0, 1); end
    for (int i = 0; i < 10; i++) begin rnd(); step(1, ($urandom % 2) == 0, 1, 0, 0, 1); end
    repeat (6) step(0, 1, 1, 0, 0, 1);

    // Reset with 2 in flight and 1 buffered: nothing stale afterwards
    for (int i = 0; i < 3; i++) begin rnd(); step(1, 0, 1, 0, 0, 1); end
    step(0, 0, 1, 1, 0, 1);
    repeat (6) step(0, 1, 1, 0, 0, 1);

    // Random traffic with occasional enable holes and resets
    for (int i = 0; i < 3000; i++) begin
      rnd();
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 8) != 0,
           ($urandom % 250) == 0, 0, 1);
    end
    repeat (6) step(0, 1, 1, 0, 0, 1);

    // Protocol error: response with nothing outstanding
    step(0, 0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1, 0);
    #1;
    chk("proto_set", proto_err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0);
      #1;
      chk("proto_sticky", proto_err, 1'b1);
    end
    step(0, 1, 0, 0, 0, 0);
    #1;
    chk("proto_sticky_ce0", proto_err, 1'b1);
    step(0, 1, 1, 1, 0, 0);
    #1;
    chk("proto_clr", proto_err, 1'b0);
    chk("proto_clr_valid", resp_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin rnd(); step(($urandom % 2) == 0, 1, 1, 0, 0, 1); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
